// File: rtl/mac_accum.sv
// Signed multiply-accumulate with valid/ready handshakes: a multiply stage, then an
// accumulate/output stage. Define MAC_ACCUM_SAT_EN for saturating adds with overflow flag.
module mac_accum #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2*DATA_W+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  localparam int PW = 2*DATA_W;

  logic              en;
  logic [PW-1:0]     a_ext, b_ext;
  logic [PW-1:0]     p_d, p_q;
  logic              p_valid_d, p_valid_q;
  logic              p_last_d, p_last_q;
  logic [ACC_W-1:0]  acc_d, acc_q;
  logic [ACC_W-1:0]  out_data_d, out_data_q;
  logic              out_valid_d, out_valid_q;
  logic [ACC_W-1:0]  p_ext, add_res;
  logic              add_ovf;

`ifdef MAC_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ACC_W:0]    sum_wide;
  logic              ovf_acc_d, ovf_acc_q;
  logic              out_ovf_d, out_ovf_q;
`endif

  // The whole pipeline advances together; it stalls only when a result is stuck.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  // acc + sign-extended product, either clamped or wrapped at ACC_W bits.
  always_comb begin
    p_ext = {{(ACC_W-PW){p_q[PW-1]}}, p_q};
`ifdef MAC_ACCUM_SAT_EN
    sum_wide = {acc_q[ACC_W-1], acc_q} + {p_ext[ACC_W-1], p_ext};
    add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (!add_ovf)            add_res = sum_wide[ACC_W-1:0];
    else if (sum_wide[ACC_W]) add_res = ACC_MIN;
    else                     add_res = ACC_MAX;
`else
    add_ovf = 1'b0;
    add_res = acc_q + p_ext;
`endif
  end

  // NOTE: every signal assigned here gets a hold/default value first, so no latches are inferred.
  always_comb begin
    a_ext       = {{DATA_W{in_a[DATA_W-1]}}, in_a};
    b_ext       = {{DATA_W{in_b[DATA_W-1]}}, in_b};
    p_d         = p_q;
    p_valid_d   = p_valid_q;
    p_last_d    = p_last_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef MAC_ACCUM_SAT_EN
    ovf_acc_d   = ovf_acc_q;
    out_ovf_d   = out_ovf_q;
`endif
    if (en) begin
      // Low PW bits of the product of sign-extended operands equal the signed product.
      p_d         = a_ext * b_ext;
      p_valid_d   = in_valid;
      p_last_d    = in_valid & in_last;
      out_valid_d = 1'b0;
      if (p_valid_q) begin
        if (p_last_q) begin
          out_data_d  = add_res;
          out_valid_d = 1'b1;
          acc_d       = '0;
`ifdef MAC_ACCUM_SAT_EN
          out_ovf_d   = ovf_acc_q | add_ovf;
          ovf_acc_d   = 1'b0;
`endif
        end else begin
          acc_d     = add_res;
`ifdef MAC_ACCUM_SAT_EN
          ovf_acc_d = ovf_acc_q | add_ovf;
`endif
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef MAC_ACCUM_SAT_EN
      ovf_acc_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef MAC_ACCUM_SAT_EN
      ovf_acc_q   <= ovf_acc_d;
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef MAC_ACCUM_SAT_EN
  assign out_ovf   = out_ovf_q;
`else
  assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum: per-cycle vector table plus hand-built reset and
// backpressure sequences. Honors MAC_ACCUM_SAT_EN for the overflow expectations.
module tb_mac_accum;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 33;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_last;
  logic [DATA_W-1:0] in_a, in_b;
  logic              out_valid, out_ready, out_ovf;
  logic [ACC_W-1:0]  out_data;

  int total = 0;
  int bad   = 0;

  mac_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // One row = one clock cycle: inputs driven before the edge, outputs expected after it.
  typedef struct {
    logic              vld;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              last;
    logic              ordy;
    logic              exp_irdy;
    logic              exp_ov;
    logic [ACC_W-1:0]  exp_od;
    logic              exp_of;
  } vec_t;

`ifdef MAC_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] BIG_SUM = 33'h0_FFFF_FFFF;
  localparam logic             BIG_OVF = 1'b1;
`else
  localparam logic [ACC_W-1:0] BIG_SUM = 33'h1_4000_0000;
  localparam logic             BIG_OVF = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_row(input vec_t r, input string tag);
    in_valid  = r.vld;
    in_a      = r.a;
    in_b      = r.b;
    in_last   = r.last;
    out_ready = r.ordy;
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(r.exp_irdy));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(r.exp_ov));
    check({tag, ".out_data"},  64'(out_data),  64'(r.exp_od));
    check({tag, ".out_ovf"},   64'(out_ovf),   64'(r.exp_of));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.out_valid", 64'(out_valid), 64'(0));
    check("reset.out_data",  64'(out_data),  64'(0));
    check("reset.out_ovf",   64'(out_ovf),   64'(0));
    check("reset.in_ready",  64'(in_ready),  64'(1));
  endtask

  vec_t vecs[20];

  initial begin
    //          vld  a         b         last ordy irdy ov  od              of
    vecs[0]  = '{1, 16'd3,    16'd4,    0, 1, 1, 0, 33'd0,          0};
    vecs[1]  = '{1, 16'd3,    16'd4,    0, 1, 1, 0, 33'd0,          0};
    vecs[2]  = '{1, 16'd3,    16'd4,    1, 1, 1, 0, 33'd0,          0};
    vecs[3]  = '{0, 16'd0,    16'd0,    0, 1, 1, 1, 33'd36,         0};
    vecs[4]  = '{1, 16'hFFFB, 16'd7,    1, 1, 1, 0, 33'd36,         0};
    vecs[5]  = '{0, 16'd0,    16'd0,    0, 1, 1, 1, 33'h1_FFFF_FFDD, 0};
    vecs[6]  = '{1, 16'd1,    16'd1,    1, 1, 1, 0, 33'h1_FFFF_FFDD, 0};
    vecs[7]  = '{1, 16'd2,    16'd3,    1, 1, 1, 1, 33'd1,          0};
    vecs[8]  = '{0, 16'd0,    16'd0,    0, 1, 1, 1, 33'd6,          0};
    vecs[9]  = '{0, 16'd0,    16'd0,    0, 1, 1, 0, 33'd6,          0};
    vecs[10] = '{1, 16'h8000, 16'h8000, 0, 1, 1, 0, 33'd6,          0};
    vecs[11] = '{1, 16'h8000, 16'h8000, 0, 1, 1, 0, 33'd6,          0};
    vecs[12] = '{1, 16'h8000, 16'h8000, 0, 1, 1, 0, 33'd6,          0};
    vecs[13] = '{1, 16'h8000, 16'h8000, 0, 1, 1, 0, 33'd6,          0};
    vecs[14] = '{1, 16'h8000, 16'h8000, 1, 1, 1, 0, 33'd6,          0};
    vecs[15] = '{0, 16'd0,    16'd0,    0, 1, 1, 1, BIG_SUM,        BIG_OVF};
    vecs[16] = '{0, 16'd0,    16'd0,    0, 1, 1, 0, BIG_SUM,        BIG_OVF};
    vecs[17] = '{1, 16'd1,    16'd1,    1, 1, 1, 0, BIG_SUM,        BIG_OVF};
    vecs[18] = '{0, 16'd0,    16'd0,    0, 1, 1, 1, 33'd1,          0};
    vecs[19] = '{0, 16'd0,    16'd0,    0, 1, 1, 0, 33'd1,          0};

    do_reset();
    for (int i = 0; i < 20; i++) run_row(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result stalls, a waiting beat is held off, then drains with no loss or duplicate.
    run_row('{1, 16'd4, 16'd5, 1, 0, 1, 0, 33'd1,  0}, "bp0");
    run_row('{1, 16'd6, 16'd7, 1, 0, 1, 1, 33'd20, 0}, "bp1");
    for (int i = 0; i < 3; i++)
      run_row('{1, 16'd1, 16'd2, 1, 0, 0, 1, 33'd20, 0}, $sformatf("bp_hold%0d", i));
    run_row('{1, 16'd1, 16'd2, 1, 1, 1, 1, 33'd42, 0}, "bp_reload");
    run_row('{0, 16'd0, 16'd0, 0, 0, 0, 1, 33'd42, 0}, "bp_hold42");
    run_row('{0, 16'd0, 16'd0, 0, 1, 1, 1, 33'd2,  0}, "bp_last");
    run_row('{0, 16'd0, 16'd0, 0, 1, 1, 0, 33'd2,  0}, "bp_drain");
    run_row('{0, 16'd0, 16'd0, 0, 1, 1, 0, 33'd2,  0}, "bp_nodup");

    // Reset in the middle of a dot product must discard the partial sum.
    run_row('{1, 16'd10, 16'd10, 0, 1, 1, 0, 33'd2, 0}, "abort0");
    run_row('{1, 16'd10, 16'd10, 0, 1, 1, 0, 33'd2, 0}, "abort1");
    do_reset();
    run_row('{1, 16'd2, 16'd2, 1, 1, 1, 0, 33'd0, 0}, "fresh0");
    run_row('{0, 16'd0, 16'd0, 0, 1, 1, 1, 33'd4, 0}, "fresh1");
    run_row('{0, 16'd0, 16'd0, 0, 1, 1, 0, 33'd4, 0}, "fresh2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed operand width.
REQ-002 SHALL have parameter ACC_W, default 2*DATA_W+1 (33), meaning signed result width; the output feeds the ReLU stage directly.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, operand pair present.
REQ-006 SHALL have port in_ready, output, 1, operand pair accepted when in_valid&in_ready.
REQ-007 SHALL have port in_a, input, DATA_W, signed operand A.
REQ-008 SHALL have port in_b, input, DATA_W, signed operand B.
REQ-009 SHALL have port in_last, input, 1, this pair is the final term of the dot product.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have port out_data, output, ACC_W, signed accumulated sum.
REQ-013 SHALL have port out_ovf, output, 1, saturation occurred in this result.

Function
REQ-014 SHALL define the pipeline enable as en = ~out_valid | out_ready, and drive in_ready = en.
REQ-015 SHALL, when en, register stage 1: p_q <= signed(in_a)*signed(in_b) (2*DATA_W bits); p_valid <= in_valid; p_last <= in_valid&in_last.
REQ-016 SHALL hold every stage register unchanged when en=0; no beat is lost or duplicated.
REQ-017 SHALL, when en and p_valid and not p_last, update acc <= add(acc, sign-extended p_q) with acc ACC_W bits wide.
REQ-018 SHALL, when en and p_valid and p_last, load out_data <= add(acc, p_q), set out_valid=1, set out_ovf to the OR of all saturation events in this dot product, and clear acc to 0.
REQ-019 SHALL clear out_valid when out_valid&out_ready and no new p_last completes in the same cycle; a simultaneous completion reloads out_valid=1 with the new result.
REQ-020 SHALL have latency 2 cycles from acceptance of the in_last beat to out_valid=1 when out_ready is held 1.
REQ-021 SHALL sustain 1 beat/cycle throughput while out_ready=1, with back-to-back dot products and no bubble between the last beat of one and the first of the next.
REQ-022 SHALL treat a single beat with in_last=1 as a complete one-term dot product.
REQ-023 SHALL keep out_data and out_ovf stable while out_valid=1 and out_ready=0.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set p_q=0, p_valid=0, p_last=0, acc=0, out_valid=0, out_data=0, out_ovf=0, discarding any partial dot product.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset.

Configuration
REQ-026 SHALL, with macro MAC_ACCUM_SAT_EN defined, clamp every add to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and record each clamp as a saturation event.
REQ-027 SHALL, without MAC_ACCUM_SAT_EN, wrap every add modulo 2^ACC_W and tie out_ovf to 0.

Verification
REQ-028 SHALL cover: (3,4),(3,4),(3,4 last) with out_ready=1 -> out_data=36, out_ovf=0, out_valid 2 cycles after the last beat.
REQ-029 SHALL cover: single beat (-5,7,last) -> out_data=33'h1_FFFF_FFDD (-35).
REQ-030 SHALL cover: 5 beats of (-32768,-32768), last on the 5th -> with SAT_EN out_data=33'h0_FFFF_FFFF and out_ovf=1; without SAT_EN out_data=33'h1_4000_0000 and out_ovf=0.
REQ-031 SHALL cover: out_ready=0 while a result is pending -> in_ready=0 and out_data is held; out_ready=1 for 1 cycle -> result consumed and the next dot product is correct.
REQ-032 SHALL cover: rst pulsed after 2 of 4 beats, then a fresh (2,2 last) -> out_data=4, with no residue from the aborted sum.
REQ-033 SHALL cover: two back-to-back dot products (1,1 last),(2,3 last) with out_ready=1 -> out_data=1 then 6 on consecutive cycles.
